alu_issue_ctrl: RTL

Operand-issue sequencer directly upstream of the registered 16-bit ALU. It accepts one decoded ALU operation per valid/ready handshake and drives the ALU's operand registers, output register, `ALUop` and `Func` in the required order. It then captures the ALU's result and flags and presents them downstream with a valid/ready handshake. It replaces hand-driven `A_write`/`B_write`/`ALUout_write` sequencing in the multicycle datapath.

---
 rtl/alu_issue_ctrl_if.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the ALU operand-issue sequencer.
// master = requester/ALU/consumer side, slave = the sequencer.
interface alu_issue_ctrl_if;
  logic        in_valid, in_ready;
  logic [1:0]  in_aluop;
  logic [3:0]  in_func;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [15:0] alu_a, alu_b;
  logic        alu_a_write, alu_b_write, alu_out_write;
  logic [1:0]  alu_aluop;
  logic [3:0]  alu_func;
  logic [15:0] alu_result;
  logic        alu_is_negative, alu_overflow, alu_is_zero;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_tag;
  logic        out_neg, out_ovf, out_zero;

  modport master (
    output in_valid, in_aluop, in_func, in_a, in_b, in_tag,
    input  in_ready,
    input  alu_a, alu_b, alu_a_write, alu_b_write, alu_out_write, alu_aluop, alu_func,
    output alu_result, alu_is_negative, alu_overflow, alu_is_zero,
    input  out_valid, out_result, out_tag, out_neg, out_ovf, out_zero,
    output out_ready
  );

  modport slave (
    input  in_valid, in_aluop, in_func, in_a, in_b, in_tag,
    output in_ready,
    output alu_a, alu_b, alu_a_write, alu_b_write, alu_out_write, alu_aluop, alu_func,
    input  alu_result, alu_is_negative, alu_overflow, alu_is_zero,
    output out_valid, out_result, out_tag, out_neg, out_ovf, out_zero,
    input  out_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Operand-issue sequencer for the registered 16-bit ALU: IDLE->LOAD->EXEC->CAP->RESP.
// Optional ALU_ISSUE_SLT_FIX_EN: signed-compare (ALUop=2, Func=7) reports neg^ovf as out_neg.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  output logic              busy,
  output logic [7:0]        ops_done
);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CAP, RESP} state_t;

  typedef struct packed {
    logic [1:0]  aluop;
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
  } req_t;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  tag;
    logic        neg;
    logic        ovf;
    logic        zero;
  } rsp_t;

  state_t     state;
  req_t       hold;
  rsp_t       rsp;
  logic [1:0] cnt;
  logic       in_ready, out_valid, a_wr, b_wr, out_wr;
  logic       neg_cap;

`ifdef ALU_ISSUE_SLT_FIX_EN
  assign neg_cap = (hold.aluop == 2'd2 && hold.func == 4'd7)
                   ? (bus.alu_is_negative ^ bus.alu_overflow) : bus.alu_is_negative;
`else
  assign neg_cap = bus.alu_is_negative;
`endif

  // ALU operand/control lines come straight from the hold registers so they
  // stay put from LOAD through CAP.
  assign bus.alu_a         = hold.a;
  assign bus.alu_b         = hold.b;
  assign bus.alu_aluop     = hold.aluop;
  assign bus.alu_func      = hold.func;
  assign bus.alu_a_write   = a_wr;
  assign bus.alu_b_write   = b_wr;
  assign bus.alu_out_write = out_wr;
  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_result    = rsp.result;
  assign bus.out_tag       = rsp.tag;
  assign bus.out_neg       = rsp.neg;
  assign bus.out_ovf       = rsp.ovf;
  assign bus.out_zero      = rsp.zero;

  // Outputs are registered against the next state, so they equal a decode of
  // the state register without any combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      rsp       <= '0;
      cnt       <= '0;
      ops_done  <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      a_wr      <= 1'b0;
      b_wr      <= 1'b0;
      out_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          hold     <= '{aluop: bus.in_aluop, func: bus.in_func,
                        a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
          state    <= LOAD;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          a_wr     <= 1'b1;
          b_wr     <= 1'b1;
        end
        LOAD: begin
          state  <= EXEC;
          a_wr   <= 1'b0;
          b_wr   <= 1'b0;
          out_wr <= 1'b1;
        end
        EXEC: begin
          state  <= CAP;
          out_wr <= 1'b0;
          cnt    <= 2'(ALU_LATENCY - 1);
        end
        CAP: begin
          if (cnt == 2'd0) begin
            rsp       <= '{result: bus.alu_result, tag: hold.tag, neg: neg_cap,
                           ovf: bus.alu_overflow, zero: bus.alu_is_zero};
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: if (bus.out_ready) begin
          out_valid <= 1'b0;
          ops_done  <= ops_done + 8'd1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
